// File: rtl/disp_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : disp_scan
// Brief    : Multiplexed 7-segment scanner for a signed BCD value; the value
//            is double-buffered so that each frame shows one coherent number.
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan #(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int DEAD     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   bcd,
    input  logic [3:0]            bcd_sgn,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS:0]       an,
    output logic                  frame
);

    localparam int              PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int              IW        = (DIGITS > 0) ? $clog2(DIGITS + 1) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   DEAD_END  = PW'(DEAD);
    localparam logic [IW-1:0]   IDX_MAX   = IW'(DIGITS);
    localparam logic [6:0]      SEG_BLANK = 7'h7F;
    localparam logic [3:0]      SGN_BLANK = 4'hF;

    logic [PW-1:0]          presc;
    logic [IW-1:0]          idx;
    logic [DIGITS*4-1:0]    pend_mag;
    logic [DIGITS*4-1:0]    shown_mag;
    logic [3:0]             pend_sgn;
    logic [3:0]             shown_sgn;

    logic                   presc_wrap;
    logic                   frame_wrap;
    logic                   is_dead;
    logic                   lz_blank;
    logic [3:0]             code;
    logic [6:0]             seg_next;
    logic [DIGITS:0]        an_next;

    function automatic logic [6:0] glyph(input logic [3:0] c);
        logic [6:0] g;
        case (c)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h3F;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    always_comb begin
        presc_wrap = (presc == PRESC_MAX);
        frame_wrap = presc_wrap && (idx == IDX_MAX);
        is_dead    = (DEAD != 0) && (presc < DEAD_END);

        // Slot DIGITS (no magnitude match below) falls through to the sign.
        code     = shown_sgn;
        lz_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                code     = shown_mag[4*i +: 4];
                lz_blank = blank_lz && (i != 0) && ((shown_mag >> (4*i)) == '0);
            end
        end

        seg_next = (is_dead || lz_blank) ? SEG_BLANK : glyph(code);

        an_next = '1;
        if (!is_dead) begin
            for (int j = 0; j <= DIGITS; j++) begin
                an_next[j] = (idx != IW'(j));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            pend_mag  <= '0;
            pend_sgn  <= SGN_BLANK;
            shown_mag <= '0;
            shown_sgn <= SGN_BLANK;
            seg       <= SEG_BLANK;
            an        <= '1;
            frame     <= 1'b0;
        end else begin
            presc <= presc_wrap ? '0 : presc + 1'b1;
            if (presc_wrap) begin
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end
            if (load) begin
                pend_mag <= bcd;
                pend_sgn <= bcd_sgn;
            end
            // Non-blocking read takes the pre-edge pending value even if load is high now.
            if (frame_wrap) begin
                shown_mag <= pend_mag;
                shown_sgn <= pend_sgn;
            end
            seg   <= seg_next;
            an    <= an_next;
            frame <= frame_wrap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_disp_scan
// Brief    : Scoreboard bench for disp_scan with a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_scan;

    localparam int DIGITS    = 2;
    localparam int SCAN_DIV  = 4;
    localparam int DEAD      = 1;
    localparam int SLOTS     = DIGITS + 1;
    localparam int FRAME_LEN = SCAN_DIV * SLOTS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bcd = 8'h00;
    logic [3:0] bcd_sgn = 4'h0;
    logic       load = 1'b0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;

    disp_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
        .clk(clk), .rst(rst), .bcd(bcd), .bcd_sgn(bcd_sgn), .load(load),
        .blank_lz(blank_lz), .seg(seg), .an(an), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] an;
        logic       frame;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         t = 0;
    logic [7:0] pend_mag = 8'h00, shown_mag = 8'h00;
    logic [3:0] pend_sgn = 4'hF, shown_sgn = 4'hF;

    function automatic logic [6:0] ref_glyph(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;
            4'h3: return 7'h30;  4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;  4'h8: return 7'h00;
            4'h9: return 7'h10;  4'hA: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: t counts clock edges since reset release.
    initial begin : model
        exp_t       e;
        int         presc, slot;
        logic [3:0] c;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                t = 0;
                pend_mag = 8'h00;  pend_sgn = 4'hF;
                shown_mag = 8'h00; shown_sgn = 4'hF;
                exp_q.delete();
            end else begin
                presc = t % SCAN_DIV;
                slot  = (t / SCAN_DIV) % SLOTS;
                if (presc < DEAD) begin
                    e.seg = 7'h7F;
                    e.an  = 3'b111;
                end else begin
                    e.an = ~(3'b001 << slot);
                    if (slot == DIGITS) begin
                        e.seg = ref_glyph(shown_sgn);
                    end else begin
                        c = shown_mag[4*slot +: 4];
                        if (blank_lz && slot > 0 && (shown_mag >> (4*slot)) == 0)
                            e.seg = 7'h7F;
                        else
                            e.seg = ref_glyph(c);
                    end
                end
                e.frame = ((t % FRAME_LEN) == FRAME_LEN - 1);
                exp_q.push_back(e);
                if (e.frame) begin
                    shown_mag = pend_mag;
                    shown_sgn = pend_sgn;
                end
                if (load) begin
                    pend_mag = bcd;
                    pend_sgn = bcd_sgn;
                end
                t++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end else begin
                    e.seg = 7'h7F; e.an = 3'b111; e.frame = 1'b0;
                end
                chk("seg",   int'(seg),   int'(e.seg));
                chk("an",    int'(an),    int'(e.an));
                chk("frame", int'(frame), int'(e.frame));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_load(input logic [7:0] m, input logic [3:0] s);
        bcd = m;
        bcd_sgn = s;
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin : stim
        step(3);
        rst = 1'b0;
        step(2 * FRAME_LEN);

        step(5);
        do_load(8'h37, 4'hA);
        step(2 * FRAME_LEN);

        blank_lz = 1'b1;
        do_load(8'h05, 4'hF);
        step(2 * FRAME_LEN);
        blank_lz = 1'b0;
        step(FRAME_LEN);

        // Next edge is the frame wrap edge.
        for (int k = 0; k < FRAME_LEN && (t % FRAME_LEN) != FRAME_LEN - 1; k++) step(1);
        do_load(8'hC9, 4'h0);
        step(3 * FRAME_LEN);

        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
            bcd[3:0] = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(9));
            bcd[7:4] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(9));
            bcd_sgn  = 4'($urandom_range(15));
            load     = ($urandom_range(7) == 0);
            step(1);
        end
        load = 1'b0;

        step(6);
        #1 rst = 1'b1;
        #1;
        chk("rst_seg",   int'(seg),   32'h7F);
        chk("rst_an",    int'(an),    32'h7);
        chk("rst_frame", int'(frame), 0);
        rst = 1'b0;
        step(2 * FRAME_LEN + 6);

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD magnitude digits accepted.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clock cycles per display slot; legal range 2 or more.
REQ-003 SHALL have parameter DEAD, default 1: blanked cycles at the start of each slot; legal range 0 to SCAN_DIV-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port bcd, input, DIGITS*4 bits: packed BCD magnitude; nibble 0 is the least significant digit.
REQ-007 SHALL have port bcd_sgn, input, 4 bits: sign code; 4'b1010 means minus, 4'b1111 means blank.
REQ-008 SHALL have port load, input, 1 bit: capture strobe for bcd and bcd_sgn.
REQ-009 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking.
REQ-010 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 SHALL have port an, output, DIGITS+1 bits: digit enables, active-low, one-hot-low, registered; an[DIGITS] is the sign position.
REQ-012 SHALL have port frame, output, 1 bit: one-cycle pulse at each frame wrap, registered.

Function
REQ-013 SHALL keep a prescaler that counts 0..SCAN_DIV-1 and wraps to 0.
REQ-014 SHALL keep a slot index 0..DIGITS, advanced by 1 when the prescaler wraps, and wrapping from DIGITS to 0.
REQ-015 SHALL, on load=1, capture bcd and bcd_sgn into a pending register on that edge.
REQ-016 SHALL copy pending into the shown register only on the edge where the index wraps DIGITS->0, so a frame never shows mixed values.
REQ-017 SHALL, when load=1 on the wrap edge, still copy the pre-edge pending value; the new value appears one frame later.
REQ-018 SHALL make consecutive loads within one frame last-wins; only the final pending value is shown.
REQ-019 SHALL assert frame for exactly the one cycle following the wrap edge.
REQ-020 SHALL drive slot i (0..DIGITS-1) from shown nibble i, and slot DIGITS from the shown sign.
REQ-021 SHALL use active-low glyphs: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, minus (1010) = 3Fh; every other code is blank = 7Fh.
REQ-022 SHALL, when blank_lz=1, show 7Fh for each magnitude digit above slot 0 whose value and all more-significant digits are 0; slot 0 is never blanked.
REQ-023 SHALL apply blanking from the shown register, not the live inputs.
REQ-024 SHALL drive seg=7Fh and an all-ones during the prescaler values 0..DEAD-1 of each slot.
REQ-025 SHALL, outside the dead time, drive an with bit[index]=0 and all other bits 1.
REQ-026 SHALL register seg, an and frame one cycle after the index/prescaler state that produces them.

Reset
REQ-027 SHALL, while rst=1, hold prescaler=0, index=0, pending and shown magnitude=0, pending and shown sign=1111, seg=7Fh, an all-ones, frame=0.
REQ-028 SHALL, when rst asserts mid-frame, clear all state immediately without waiting for a clock edge; a load in the same cycle is discarded.
REQ-029 SHALL, after rst deasserts, start at slot 0 with prescaler 0; the first frame shows "0" with a blank sign.

Verification
REQ-030 SHALL cover: DIGITS=2, SCAN_DIV=4, DEAD=1; reset, then no load -> an cycles 110, 101, 011 every 4 clocks; slot 0 seg=40h; slots 1 and 2 seg=40h and 7Fh with blank_lz=0.
REQ-031 SHALL cover: load bcd=8'h37, bcd_sgn=1010 mid-frame -> unchanged until the next frame pulse, then slots show 78h, 30h, 3Fh.
REQ-032 SHALL cover: bcd=8'h05 with blank_lz=1 -> slot 1 shows 7Fh and slot 0 shows 12h; with blank_lz=0, slot 1 shows 40h.
REQ-033 SHALL cover: load asserted exactly on the wrap edge -> the old value is shown for one more frame and the new value is shown in the following frame.
REQ-034 SHALL cover: rst pulsed between clock edges mid-slot -> seg=7Fh and an=111 immediately, and the scan restarts at slot 0.
REQ-035 SHALL cover: bcd nibble 4'hC -> that slot shows 7Fh; bcd_sgn=0000 -> the sign slot shows 40h (glyph 0), per REQ-021.
